// File: rtl/uart_baud_gen.sv
// UART bit-timing generator: 8-rate table, frame sequencing with mid/end-of-bit strobes.
// Define UART_BAUD_OS_TICK_EN to build the oversample tick used by RX majority sampling.
`timescale 1ns/1ps
module uart_baud_gen #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int FRAME_BITS  = 10,
  parameter int OVERSAMPLE  = 16,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] baud_sel,
  output logic       busy,
  output logic       clk_bps,
  output logic       bit_end,
  output logic [3:0] bit_idx,
  output logic       frame_done,
  output logic       os_tick
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] half_q;
  logic             accept;
  logic             bit_wrap;

  if (FRAME_BITS < 2 || FRAME_BITS > 15 || OVERSAMPLE < 1) begin : g_param_check
    $error("uart_baud_gen: FRAME_BITS must be 2..15 and OVERSAMPLE at least 1");
  end

  function automatic logic [CNT_W-1:0] div_of(input logic [2:0] sel);
    int rate;
    case (sel)
      3'd0:    rate = 1200;
      3'd1:    rate = 2400;
      3'd2:    rate = 4800;
      3'd3:    rate = 9600;
      3'd4:    rate = 19200;
      3'd5:    rate = 38400;
      3'd6:    rate = 57600;
      default: rate = 115200;
    endcase
    return CNT_W'(CLK_FREQ_HZ / rate);
  endfunction

  assign accept   = (state == IDLE) && start && !abort;
  assign bit_wrap = (cnt == div_q - 1'b1);

  // Strobes are computed from the current count and show up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div_q      <= '0;
      half_q     <= '0;
      busy       <= 1'b0;
      clk_bps    <= 1'b0;
      bit_end    <= 1'b0;
      bit_idx    <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_bps    <= 1'b0;
          bit_end    <= 1'b0;
          frame_done <= 1'b0;
          if (accept) begin
            state   <= RUN;
            cnt     <= '0;
            bit_idx <= 4'd0;
            busy    <= 1'b1;
            div_q   <= div_of(baud_sel);
            half_q  <= div_of(baud_sel) >> 1;
          end
        end
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
            bit_idx    <= 4'd0;
            clk_bps    <= 1'b0;
            bit_end    <= 1'b0;
            frame_done <= 1'b0;
          end else begin
            clk_bps    <= (cnt == half_q);
            bit_end    <= bit_wrap;
            frame_done <= 1'b0;
            if (bit_wrap) begin
              cnt <= '0;
              // Last bit closes the frame on the same edge as its bit_end.
              if (bit_idx == LAST_IDX) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
                bit_idx    <= 4'd0;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_BAUD_OS_TICK_EN
  logic [CNT_W-1:0] os_div;
  logic [CNT_W-1:0] os_cnt;
  logic             os_wrap;

  assign os_wrap = (os_cnt == os_div - 1'b1);

  // The oversample phase realigns to every bit boundary so ticks never drift across bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      os_div  <= '0;
      os_cnt  <= '0;
      os_tick <= 1'b0;
    end else if (state == IDLE) begin
      os_tick <= 1'b0;
      os_cnt  <= '0;
      if (accept) begin
        os_div <= CNT_W'(div_of(baud_sel) / CNT_W'(OVERSAMPLE));
      end
    end else if (abort) begin
      os_tick <= 1'b0;
      os_cnt  <= '0;
    end else begin
      os_tick <= os_wrap && !(bit_wrap && bit_idx == LAST_IDX);
      os_cnt  <= (bit_wrap || os_wrap) ? '0 : os_cnt + 1'b1;
    end
  end
`else
  assign os_tick = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen at 25 MHz; checks frame timing, abort, reset and back-to-back frames.
// Oversample checks follow UART_BAUD_OS_TICK_EN.
`timescale 1ns/1ps
module tb_uart_baud_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [2:0] baud_sel;
  logic       busy;
  logic       clk_bps;
  logic       bit_end;
  logic [3:0] bit_idx;
  logic       frame_done;
  logic       os_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  int exp_period = 2604;

  int bps_cnt, be_cnt, done_cnt, first_bps, first_be, last_be;
  int period_err, idx_err, coincide, os_total, os_in_bit, os_last, os_err, first_os;
  int os_ever = 0;

  uart_baud_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .baud_sel   (baud_sel),
    .busy       (busy),
    .clk_bps    (clk_bps),
    .bit_end    (bit_end),
    .bit_idx    (bit_idx),
    .frame_done (frame_done),
    .os_tick    (os_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearMonitor();
    bps_cnt = 0; be_cnt = 0; done_cnt = 0;
    first_bps = -1; first_be = -1; last_be = -1;
    period_err = 0; idx_err = 0; coincide = 0;
    os_total = 0; os_in_bit = 0; os_last = -1; os_err = 0; first_os = -1;
  endtask

  // Cycle numbering: start is sampled at edge 0, cycle k is the period after edge k-1.
  always @(negedge clk) begin
    int rel;
    rel = cyc - base;
    if (os_tick) begin
      os_ever++;
      os_total++;
      if (first_os < 0) first_os = rel;
      if (os_in_bit > 0 && rel - os_last != 162) os_err++;
      if (!busy) os_err++;
      os_in_bit++;
      os_last = rel;
    end
    if (clk_bps) begin
      bps_cnt++;
      if (first_bps < 0) first_bps = rel;
      if (bit_end) coincide++;
    end
    if (bit_end) begin
      be_cnt++;
      if (first_be < 0) first_be = rel;
      if (last_be >= 0 && rel - last_be != exp_period) period_err++;
      last_be = rel;
      if (bit_idx != be_cnt % 10) idx_err++;
`ifdef UART_BAUD_OS_TICK_EN
      if (exp_period == 2604 && os_in_bit != 16) os_err++;
`endif
      os_in_bit = 0;
    end
    if (frame_done) begin
      done_cnt++;
      last_be = -1;
    end
  end

  task automatic applyStimulus(input logic [2:0] sel, input bit hold);
    @(negedge clk);
    #1;
    clearMonitor();
    baud_sel = sel;
    start = 1'b1;
    base = cyc;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic waitRel(input int n);
    while (cyc - base < n) @(negedge clk);
  endtask

  task automatic waitDone(input int budget);
    int k;
    k = 0;
    while (!frame_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("frame_done_seen", frame_done, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; baud_sel = 3'd0;
    clearMonitor();
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_strobes", {clk_bps, bit_end, frame_done, os_tick}, 0);
    checkOutput("rst_idx", bit_idx, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] nominal 9600 frame");
    exp_period = 2604;
    applyStimulus(3'd3, 1'b0);
    checkOutput("t1_busy_c1", busy, 1);
    checkOutput("t1_idx_c1", bit_idx, 0);
    waitDone(30000);
    checkOutput("t1_done_cycle", cyc - base, 26041);
    checkOutput("t1_busy_at_done", busy, 0);
    checkOutput("t1_bit_end_at_done", bit_end, 1);
    checkOutput("t1_idx_at_done", bit_idx, 0);
    #1;
    checkOutput("t1_first_bps", first_bps, 1304);
    checkOutput("t1_first_bit_end", first_be, 2605);
    checkOutput("t1_bps_count", bps_cnt, 10);
    checkOutput("t1_bit_end_count", be_cnt, 10);
    checkOutput("t1_period_err", period_err, 0);
    checkOutput("t1_idx_err", idx_err, 0);
    checkOutput("t1_coincide", coincide, 0);
`ifdef UART_BAUD_OS_TICK_EN
    checkOutput("t1_os_total", os_total, 160);
    checkOutput("t1_os_first", first_os, 163);
    checkOutput("t1_os_err", os_err, 0);
`endif

    $display("[TB] 115200 frame with baud_sel change mid-frame");
    exp_period = 217;
    applyStimulus(3'd7, 1'b0);
    waitRel(100);
    baud_sel = 3'd0;
    waitDone(3000);
    checkOutput("t2_done_cycle", cyc - base, 2171);
    #1;
    checkOutput("t2_first_bit_end", first_be, 218);
    checkOutput("t2_period_err", period_err, 0);
    checkOutput("t2_bit_end_count", be_cnt, 10);

    $display("[TB] abort mid-frame");
    exp_period = 2604;
    applyStimulus(3'd3, 1'b0);
    waitRel(3000);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t3_busy_after_abort", busy, 0);
    checkOutput("t3_idx_after_abort", bit_idx, 0);
    checkOutput("t3_done_after_abort", frame_done, 0);
    #1;
    clearMonitor();
    repeat (3000) @(negedge clk);
    #1;
    checkOutput("t3_strobes_after_abort", bps_cnt + be_cnt + done_cnt, 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("t3_abort_start_busy", busy, 0);
    @(negedge clk);
    checkOutput("t3_abort_start_busy2", busy, 0);

    $display("[TB] back-to-back frames with start held");
    exp_period = 217;
    applyStimulus(3'd7, 1'b1);
    waitDone(3000);
    checkOutput("t4_done1_cycle", cyc - base, 2171);
    checkOutput("t4_busy_at_done", busy, 0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("t4_busy_restart", busy, 1);
    checkOutput("t4_idx_restart", bit_idx, 0);
    waitRel(3000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(3000);
    checkOutput("t4_done2_cycle", cyc - base, 4342);
    #1;
    checkOutput("t4_bit_end_count", be_cnt, 20);
    checkOutput("t4_done_count", done_cnt, 2);
    checkOutput("t4_period_err", period_err, 0);

    $display("[TB] reset mid-frame");
    exp_period = 2604;
    applyStimulus(3'd3, 1'b0);
    waitRel(5000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_busy_after_rst", busy, 0);
    checkOutput("t5_outs_after_rst", {clk_bps, bit_end, frame_done, os_tick, bit_idx}, 0);
    applyStimulus(3'd3, 1'b0);
    waitRel(2605);
    checkOutput("t5_bit_end_2605", bit_end, 1);
    checkOutput("t5_idx_2605", bit_idx, 1);
    #1;
    checkOutput("t5_first_bps", first_bps, 1304);
    checkOutput("t5_done_count", done_cnt, 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t5_busy_end", busy, 0);

`ifndef UART_BAUD_OS_TICK_EN
    checkOutput("os_tick_never", os_ever, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
